// File: rtl/mul_div_if.sv
// ---------------------------------------------------------------------------
// mul_div_if
//   Issue/result bundle between the execute-stage issuer and the iterative
//   RV32M multiply/divide unit.
//
//   start     issuer -> unit   request, held with operands until done
//   flush     issuer -> unit   synchronous abort (branch/jump squash)
//   Op        issuer -> unit   funct3 of the M-extension instruction
//   SrcA      issuer -> unit   rs1 value (dividend / multiplicand)
//   SrcB      issuer -> unit   rs2 value (divisor / multiplier)
//   busy      unit -> issuer   operation in flight; pipeline stall request
//   done      unit -> issuer   one-cycle pulse, MDResult valid
//   MDResult  unit -> issuer   result, held until the next accepted start
// ---------------------------------------------------------------------------
interface mul_div_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  start;
    logic                  flush;
    logic [2:0]            Op;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] MDResult;

    modport master (
        output start, flush, Op, SrcA, SrcB,
        input  busy, done, MDResult
    );

    modport slave (
        input  start, flush, Op, SrcA, SrcB,
        output busy, done, MDResult
    );
endinterface

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative RV32M multiply/divide unit sitting beside the combinational ALU.
//   Multiplication is shift-add over a 2*DATA_WIDTH product; division is
//   restoring division. Both work on operand magnitudes and apply the result
//   sign in the DONE cycle, so every op takes the same fixed latency.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   md     mul_div_if.slave: start/flush/Op/SrcA/SrcB in,
//                            busy/done/MDResult out
//
//   Timing: start accepted on edge k -> CALC for DATA_WIDTH cycles -> DONE
//   for one cycle, where the sign fix-up is computed; the edge leaving DONE
//   registers MDResult and raises done, so done is high in the cycle after
//   edge k+DATA_WIDTH+1. That cycle is also the single IDLE cycle in which a
//   held start is accepted again.
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_div_if.slave     md
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [2:0]       op_r;
    logic             sign_a_r;     // SrcA was negative and treated as signed
    logic             sign_b_r;     // SrcB was negative and treated as signed
    logic             b_zero_r;     // divisor was zero
    logic [W-1:0]     oper_r;       // multiplicand |SrcA| or divisor |SrcB|
    logic [2*W-1:0]   acc_r;        // product; low half doubles as quotient
    logic [W:0]       rem_r;        // partial remainder
    logic [CW-1:0]    count_r;
    logic             busy_r;
    logic             done_r;
    logic [W-1:0]     result_r;

    logic             a_signed_s;
    logic             b_signed_s;
    logic             neg_a_s;
    logic             neg_b_s;
    logic [W-1:0]     mag_a_s;
    logic [W-1:0]     mag_b_s;
    logic [W:0]       mul_sum_s;
    logic [2*W-1:0]   mul_next_s;
    logic [W:0]       div_shift_s;
    logic             div_ge_s;
    logic [W:0]       div_rem_next_s;
    logic [2*W-1:0]   prod_fix_s;
    logic [W-1:0]     quot_fix_s;
    logic [W-1:0]     rem_fix_s;
    logic [W-1:0]     result_s;

    // Operand sign interpretation and magnitudes at accept time
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (md.Op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            OP_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        neg_a_s = a_signed_s & md.SrcA[W-1];
        neg_b_s = b_signed_s & md.SrcB[W-1];
        if (neg_a_s) begin
            mag_a_s = ~md.SrcA + {{(W-1){1'b0}}, 1'b1};
        end else begin
            mag_a_s = md.SrcA;
        end
        if (neg_b_s) begin
            mag_b_s = ~md.SrcB + {{(W-1){1'b0}}, 1'b1};
        end else begin
            mag_b_s = md.SrcB;
        end
    end

    // One iteration of shift-add multiply and of restoring division
    always_comb begin
        // add multiplicand into the high half when the current multiplier bit is set
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*W-1:W]} + {1'b0, oper_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*W-1:W]};
        end
        mul_next_s = {mul_sum_s, acc_r[W-1:1]};

        // bring the next dividend bit in from the top of the quotient register
        div_shift_s = {rem_r[W-1:0], acc_r[W-1]};
        div_ge_s    = (div_shift_s >= {1'b0, oper_r});
        if (div_ge_s) begin
            div_rem_next_s = div_shift_s - {1'b0, oper_r};
        end else begin
            div_rem_next_s = div_shift_s;
        end
    end

    // Sign fix-up and result selection, evaluated while in DONE
    always_comb begin
        if (sign_a_r ^ sign_b_r) begin
            prod_fix_s = ~acc_r + {{(2*W-1){1'b0}}, 1'b1};
        end else begin
            prod_fix_s = acc_r;
        end

        // a zero divisor must give all ones regardless of the dividend sign
        if (b_zero_r) begin
            quot_fix_s = {W{1'b1}};
        end else if (sign_a_r ^ sign_b_r) begin
            quot_fix_s = ~acc_r[W-1:0] + {{(W-1){1'b0}}, 1'b1};
        end else begin
            quot_fix_s = acc_r[W-1:0];
        end

        // remainder takes the dividend sign; with a zero divisor this returns SrcA
        if (sign_a_r) begin
            rem_fix_s = ~rem_r[W-1:0] + {{(W-1){1'b0}}, 1'b1};
        end else begin
            rem_fix_s = rem_r[W-1:0];
        end

        result_s = {W{1'b0}};
        case (op_r)
            OP_MUL:                         result_s = prod_fix_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   result_s = prod_fix_s[2*W-1:W];
            OP_DIV, OP_DIVU:                result_s = quot_fix_s;
            OP_REM, OP_REMU:                result_s = rem_fix_s;
            default:                        result_s = {W{1'b0}};
        endcase
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            op_r     <= 3'b000;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            b_zero_r <= 1'b0;
            oper_r   <= {W{1'b0}};
            acc_r    <= {(2*W){1'b0}};
            rem_r    <= {(W+1){1'b0}};
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (md.start && !md.flush) begin
                        state_r  <= CALC;
                        busy_r   <= 1'b1;
                        op_r     <= md.Op;
                        sign_a_r <= neg_a_s;
                        sign_b_r <= neg_b_s;
                        b_zero_r <= (md.SrcB == {W{1'b0}});
                        count_r  <= {CW{1'b0}};
                        rem_r    <= {(W+1){1'b0}};
                        if (md.Op[2]) begin
                            // divide: quotient register starts as the dividend
                            oper_r <= mag_b_s;
                            acc_r  <= {{W{1'b0}}, mag_a_s};
                        end else begin
                            // multiply: low half starts as the multiplier
                            oper_r <= mag_a_s;
                            acc_r  <= {{W{1'b0}}, mag_b_s};
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                CALC: begin
                    done_r <= 1'b0;
                    if (md.flush) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                        if (op_r[2]) begin
                            acc_r <= {acc_r[2*W-1:W], acc_r[W-2:0], div_ge_s};
                            rem_r <= div_rem_next_s;
                        end else begin
                            acc_r <= mul_next_s;
                            rem_r <= rem_r;
                        end
                        if (count_r == CW'(W - 1)) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    if (md.flush) begin
                        done_r <= 1'b0;
                    end else begin
                        done_r   <= 1'b1;
                        result_r <= result_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign md.busy     = busy_r;
    assign md.done     = done_r;
    assign md.MDResult = result_r;

endmodule
